mem_dp_master: RTL and testbench
================================

# mem_dp_master

Data-port bus initiator that sits between the CPU's execute/memory stage and the Harvard memory's data port. It accepts one load or store request at a time, converts the byte address and access size into a word-aligned address, byte-enables and lane-replicated write data, and holds the bus strobes while the memory asserts `stall`. For loads it extracts and sign- or zero-extends the addressed lanes. Misaligned accesses are rejected without touching the bus.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a cycle with `req_valid & req_ready`.
- `req_store` in 1: 1 = store, 0 = load.
- `req_size` in 3: access type. Loads: LB=000, LH=001, LW=011, LBU=100, LHU=101. Stores: SB=000, SH=001, SW=011. Any other code is treated as misaligned.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse, for loads and stores.
- `resp_data` out 32: extended load result; 0 for stores and errors.
- `resp_err` out 1: misaligned address or illegal size; qualified by `resp_valid`.
- `dp_address` out 32: word-aligned, `{addr[31:2],2'b00}`.
- `writedata` out 32: lane-replicated store data.
- `byteenable` out 4: lane mask; lane 0 = bits 7:0 = lowest byte address (little-endian).
- `read_dp` out 1: read strobe.
- `write_dp` out 1: write strobe.
- `dp_readdata` in 32: memory read data; disabled lanes read 0x00.
- `stall` in 1: memory not ready; hold the access.

## Operation
- FSM states:
  - IDLE: `req_ready = ~rst`. On accept, latch store/size/addr/wdata. Go to ERR if the access is misaligned or the size is illegal, otherwise go to ACCESS.
  - ACCESS: drive `read_dp` (load) or `write_dp` (store), plus `dp_address`, `byteenable` and `writedata` from the latched request.
    - If `stall` = 1: stay in ACCESS with all bus outputs held bit-identical.
    - If `stall` = 0: loads capture `dp_readdata`; go to RESP.
  - RESP: `resp_valid` = 1 and `resp_err` = 0; go to IDLE.
  - ERR: `resp_valid` = 1, `resp_err` = 1, `resp_data` = 0; no bus strobes; go to IDLE.
- Misalignment rules:
  - Half access: misaligned if `addr[0]` = 1.
  - Word access: misaligned if `addr[1:0] != 0`.
- Byte-enables:
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `addr[1] ? 4'b1100 : 4'b0011`.
  - Word: `4'b1111`.
- Write data:
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: `wdata`.
- Load extraction: `lane = captured >> (8*addr[1:0])`.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- All bus outputs are 0 outside ACCESS.
- `stall` is ignored outside ACCESS.
- `req_valid` is ignored outside IDLE.

## Timing
- Reset values (the cycle after `rst` is sampled high): state = IDLE; all bus outputs, `resp_valid`, `resp_err` and `resp_data` = 0. `req_ready` = 0 while `rst` is high, 1 from the first cycle after.
- Latency with no stall: accept at cycle N, ACCESS at N+1, `resp_valid` at N+2. Each stall cycle adds one cycle.
- Throughput: one request per 3 cycles unstalled. Misaligned requests take 2 cycles (accept at N, `resp_valid` at N+1).
- Bus outputs are registered-state decoded and are stable for the whole ACCESS period. The memory may commit a store on every edge with `write_dp` high; repeats under stall are idempotent because address and data are held.
- `resp_data` and `resp_err` are valid only while `resp_valid` = 1. They hold their value until the next response.
- Reset in ACCESS or RESP: the transaction is dropped, strobes go low on the next cycle, and no `resp_valid` is produced.

## Structure
- Package `mem_bus_pkg`: size encodings (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_BU`, `SZ_HU`) and the state enum `{IDLE, ACCESS, RESP, ERR}`.
- Sub-module `lsu_lane_align` (combinational): byte-enable generation, store replication, load shift/extension and misalignment detection.
- Top level: FSM plus latched request and captured read data.

## Test plan
- Reset: hold `rst` 2 cycles during a request. Required: all outputs 0 and `req_ready` = 0; after release `req_ready` = 1 and `resp_valid` stays 0.
- LB, addr `0x102`, memory word `0x12F45678`. Required: `dp_address = 0x100`, `byteenable = 4'b0100`, `resp_data = 0xFFFFFFF4` at cycle N+2.
- LHU and LH, addr `0x106`, word `0x8001_0000`. Required: `byteenable = 4'b1100`; LHU → `0x00008001`; LH → `0xFFFF8001`.
- SB, addr `0x103`, wdata `0xAB`. Required: `writedata = 0xABABABAB`, `byteenable = 4'b1000`; a readback LW returns `0xABxxxxxx` with the other bytes unchanged.
- SW to `0x200` with `stall` high for 3 ACCESS cycles. Required: bus outputs held constant for 4 cycles; `resp_valid` at N+5.
- LW to `0x102` and SH to `0x101`. Required: `read_dp` and `write_dp` never asserted; `resp_valid = resp_err = 1` at N+1, `resp_data` = 0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-port bus initiator.
// Contents:
//   SZ_*   access size encodings carried on req_size
//   IDLE / ACCESS / RESP / ERR   FSM state encodings (state_t)
package mem_bus_pkg;

    // Access size codes (loads use all five, stores only B/H/W)
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t RESP   = 2'd2;
    localparam state_t ERR    = 2'd3;

endpackage

// File: rtl/mem_dp_master_if.sv
// Request/response handshake and Harvard data-port bus bundle.
// master modport: the initiator (mem_dp_master).
// slave modport:  the CPU-side requester plus the memory data port.
// Signals:
//   req_valid/req_ready/req_store/req_size/req_addr/req_wdata  request side
//   resp_valid/resp_data/resp_err                               response side
//   dp_address/writedata/byteenable/read_dp/write_dp            bus outputs
//   dp_readdata/stall                                           bus inputs
interface mem_dp_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] dp_address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        read_dp;
    logic        write_dp;
    logic [31:0] dp_readdata;
    logic        stall;

    modport master (
        input  req_valid, req_store, req_size, req_addr, req_wdata,
        input  dp_readdata, stall,
        output req_ready, resp_valid, resp_data, resp_err,
        output dp_address, writedata, byteenable, read_dp, write_dp
    );

    modport slave (
        output req_valid, req_store, req_size, req_addr, req_wdata,
        output dp_readdata, stall,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  dp_address, writedata, byteenable, read_dp, write_dp
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the data-port initiator.
// Ports:
//   store, size, addr_lo  access descriptor (addr_lo = byte address bits 1:0)
//   wdata                 right-justified store data
//   rdata                 word returned by the memory
//   byteenable            lane mask for the access
//   writedata             store data replicated across lanes
//   load_data             addressed lanes shifted down and extended
//   misaligned            access cannot be issued (alignment or illegal size)
module lsu_lane_align
    import mem_bus_pkg::*;
(
    input  logic        store,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;

    // The unsigned size codes exist only for loads, so a store using them is
    // rejected the same way as an unknown code.
    always_comb begin
        shifted    = rdata >> {addr_lo, 3'b000};
        byteenable = 4'b0000;
        writedata  = 32'h0;
        load_data  = shifted;
        misaligned = 1'b1;
        case (size)
            SZ_B, SZ_BU: begin
                byteenable = 4'b0001 << addr_lo;
                writedata  = {4{wdata[7:0]}};
                load_data  = (size == SZ_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                            : {24'h0, shifted[7:0]};
                misaligned = store && (size == SZ_BU);
            end
            SZ_H, SZ_HU: begin
                byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
                writedata  = {2{wdata[15:0]}};
                load_data  = (size == SZ_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                            : {16'h0, shifted[15:0]};
                misaligned = addr_lo[0] || (store && (size == SZ_HU));
            end
            SZ_W: begin
                byteenable = 4'b1111;
                writedata  = wdata;
                load_data  = shifted;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_dp_master.sv
// Data-port bus initiator: one load/store at a time between the CPU memory
// stage and the Harvard memory data port.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   mem_dp_master_if master modport (request, response, memory bus)
module mem_dp_master
    import mem_bus_pkg::*;
(
    input logic            clk,
    input logic            rst,
    mem_dp_master_if.master bus
);

    state_t      state;
    logic        lat_store;
    logic [2:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] resp_data_q;
    logic        resp_err_q;

    logic        accept;
    logic        in_idle;
    logic        in_access;
    logic        al_store;
    logic [2:0]  al_size;
    logic [1:0]  al_addr_lo;
    logic [31:0] al_wdata;
    logic [3:0]  al_be;
    logic [31:0] al_wd;
    logic [31:0] al_load;
    logic        al_mis;

    assign in_idle   = (state == IDLE);
    assign in_access = (state == ACCESS);
    assign accept    = bus.req_valid & bus.req_ready;

    // In IDLE the lane logic looks at the live request so misalignment is
    // known at accept time; afterwards it works from the latched copy.
    assign al_store   = in_idle ? bus.req_store     : lat_store;
    assign al_size    = in_idle ? bus.req_size      : lat_size;
    assign al_addr_lo = in_idle ? bus.req_addr[1:0] : lat_addr[1:0];
    assign al_wdata   = in_idle ? bus.req_wdata     : lat_wdata;

    lsu_lane_align u_align (
        .store      (al_store),
        .size       (al_size),
        .addr_lo    (al_addr_lo),
        .wdata      (al_wdata),
        .rdata      (bus.dp_readdata),
        .byteenable (al_be),
        .writedata  (al_wd),
        .load_data  (al_load),
        .misaligned (al_mis)
    );

    // Bus outputs decode only from registered state and latched request, so
    // they stay bit-identical for the whole (possibly stalled) ACCESS period.
    assign bus.req_ready  = in_idle & ~rst;
    assign bus.dp_address = in_access ? {lat_addr[31:2], 2'b00} : 32'h0;
    assign bus.byteenable = in_access ? al_be : 4'b0000;
    assign bus.writedata  = (in_access & lat_store) ? al_wd : 32'h0;
    assign bus.read_dp    = in_access & ~lat_store;
    assign bus.write_dp   = in_access & lat_store;
    assign bus.resp_valid = (state == RESP) || (state == ERR);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_store   <= 1'b0;
            lat_size    <= 3'b000;
            lat_addr    <= 32'h0;
            lat_wdata   <= 32'h0;
            resp_data_q <= 32'h0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_store <= bus.req_store;
                        lat_size  <= bus.req_size;
                        lat_addr  <= bus.req_addr;
                        lat_wdata <= bus.req_wdata;
                        if (al_mis) begin
                            state       <= ERR;
                            resp_data_q <= 32'h0;
                            resp_err_q  <= 1'b1;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!bus.stall) begin
                        resp_data_q <= lat_store ? 32'h0 : al_load;
                        resp_err_q  <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dp_master.sv
// Self-checking bench for mem_dp_master: a table of requests with
// hand-derived expected bus and response values, a small byte-lane memory
// model acting as the data port, a response scoreboard, and hand-written
// reset sequences.
module tb_mem_dp_master;

    typedef struct {
        logic        store;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nstall;
        logic        exp_err;
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_data;
    logic [31:0] mem [0:255];
    logic [31:0] lane_mask;
    exp_t        sb_q [$];
    vec_t        vecs [15];
    vec_t        recov;

    mem_dp_master_if bus ();

    mem_dp_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Data-port model: disabled lanes read as zero
    assign lane_mask = {{8{bus.byteenable[3]}}, {8{bus.byteenable[2]}},
                        {8{bus.byteenable[1]}}, {8{bus.byteenable[0]}}};
    assign bus.dp_readdata = bus.read_dp ? (mem[bus.dp_address[9:2]] & lane_mask) : 32'h0;

    // Data-port model: commit enabled lanes on every edge with write_dp high
    always @(posedge clk) begin
        if (bus.write_dp) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byteenable[i])
                    mem[bus.dp_address[9:2]][8*i +: 8] <= bus.writedata[8*i +: 8];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest pending request
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected resp_valid: got 1 expected 0");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("sb resp_err", {31'h0, bus.resp_err}, {31'h0, e.err});
                checkOutput("sb resp_data", bus.resp_data, e.data);
            end
        end
    end

    // One full transaction: drive, check bus each ACCESS cycle, check latency
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        checkOutput("idle resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        checkOutput("held resp_data", bus.resp_data, last_data);
        checkOutput("req_ready", {31'h0, bus.req_ready}, 32'h1);
        bus.req_store = v.store;
        bus.req_size  = v.size;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.req_valid = 1'b1;
        sb_q.push_back('{v.exp_err, v.exp_data});
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (v.exp_err) begin
            checkOutput("err resp_valid", {31'h0, bus.resp_valid}, 32'h1);
            checkOutput("err read_dp", {31'h0, bus.read_dp}, 32'h0);
            checkOutput("err write_dp", {31'h0, bus.write_dp}, 32'h0);
        end else begin
            for (int k = 0; k <= v.nstall; k++) begin
                bus.stall = (k < v.nstall);
                checkOutput("read_dp", {31'h0, bus.read_dp}, {31'h0, ~v.store});
                checkOutput("write_dp", {31'h0, bus.write_dp}, {31'h0, v.store});
                checkOutput("dp_address", bus.dp_address, v.exp_addr);
                checkOutput("byteenable", {28'h0, bus.byteenable}, {28'h0, v.exp_be});
                if (v.store)
                    checkOutput("writedata", bus.writedata, v.exp_wd);
                checkOutput("access resp_valid", {31'h0, bus.resp_valid}, 32'h0);
                @(posedge clk);
                @(negedge clk);
            end
            bus.stall = 1'b0;
            checkOutput("latency resp_valid", {31'h0, bus.resp_valid}, 32'h1);
        end
        last_data = v.exp_data;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h12F45678;
        mem[8'h41] = 32'h8001_0000;

        // store size addr wdata nstall | err data addr be wd
        vecs[0]  = '{1'b0, 3'b000, 32'h102, 32'h0,        0, 1'b0, 32'hFFFFFFF4, 32'h100, 4'b0100, 32'h0};
        vecs[1]  = '{1'b0, 3'b101, 32'h106, 32'h0,        0, 1'b0, 32'h00008001, 32'h104, 4'b1100, 32'h0};
        vecs[2]  = '{1'b0, 3'b001, 32'h106, 32'h0,        1, 1'b0, 32'hFFFF8001, 32'h104, 4'b1100, 32'h0};
        vecs[3]  = '{1'b1, 3'b000, 32'h103, 32'h000000AB, 0, 1'b0, 32'h0,        32'h100, 4'b1000, 32'hABABABAB};
        vecs[4]  = '{1'b0, 3'b011, 32'h100, 32'h0,        0, 1'b0, 32'hABF45678, 32'h100, 4'b1111, 32'h0};
        vecs[5]  = '{1'b1, 3'b011, 32'h200, 32'hCAFEF00D, 3, 1'b0, 32'h0,        32'h200, 4'b1111, 32'hCAFEF00D};
        vecs[6]  = '{1'b1, 3'b001, 32'h202, 32'hFFFF1234, 1, 1'b0, 32'h0,        32'h200, 4'b1100, 32'h12341234};
        vecs[7]  = '{1'b0, 3'b011, 32'h200, 32'h0,        2, 1'b0, 32'h1234F00D, 32'h200, 4'b1111, 32'h0};
        vecs[8]  = '{1'b0, 3'b100, 32'h201, 32'h0,        0, 1'b0, 32'h000000F0, 32'h200, 4'b0010, 32'h0};
        vecs[9]  = '{1'b0, 3'b000, 32'h200, 32'h0,        0, 1'b0, 32'h0000000D, 32'h200, 4'b0001, 32'h0};
        vecs[10] = '{1'b0, 3'b011, 32'h102, 32'h0,        0, 1'b1, 32'h0,        32'h0,   4'b0000, 32'h0};
        vecs[11] = '{1'b1, 3'b001, 32'h101, 32'h5555,     0, 1'b1, 32'h0,        32'h0,   4'b0000, 32'h0};
        vecs[12] = '{1'b0, 3'b010, 32'h100, 32'h0,        0, 1'b1, 32'h0,        32'h0,   4'b0000, 32'h0};
        vecs[13] = '{1'b1, 3'b100, 32'h100, 32'h77,       0, 1'b1, 32'h0,        32'h0,   4'b0000, 32'h0};
        vecs[14] = '{1'b0, 3'b001, 32'h100, 32'h0,        0, 1'b0, 32'h00005678, 32'h100, 4'b0011, 32'h0};
        recov    = '{1'b0, 3'b101, 32'h202, 32'h0,        0, 1'b0, 32'h00001234, 32'h200, 4'b1100, 32'h0};

        // Reset held two cycles with a request present
        rst           = 1'b1;
        bus.stall     = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_store = 1'b0;
        bus.req_size  = 3'b011;
        bus.req_addr  = 32'h100;
        bus.req_wdata = 32'h0;
        last_data     = 32'h0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst req_ready", {31'h0, bus.req_ready}, 32'h0);
            checkOutput("rst read_dp", {31'h0, bus.read_dp}, 32'h0);
            checkOutput("rst write_dp", {31'h0, bus.write_dp}, 32'h0);
            checkOutput("rst dp_address", bus.dp_address, 32'h0);
            checkOutput("rst byteenable", {28'h0, bus.byteenable}, 32'h0);
            checkOutput("rst writedata", bus.writedata, 32'h0);
            checkOutput("rst resp_valid", {31'h0, bus.resp_valid}, 32'h0);
            checkOutput("rst resp_err", {31'h0, bus.resp_err}, 32'h0);
            checkOutput("rst resp_data", bus.resp_data, 32'h0);
        end
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("post-rst req_ready", {31'h0, bus.req_ready}, 32'h1);
        checkOutput("post-rst resp_valid", {31'h0, bus.resp_valid}, 32'h0);

        for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

        // Reset while ACCESS is active: transaction dropped, no response
        @(negedge clk);
        bus.req_store = 1'b0;
        bus.req_size  = 3'b011;
        bus.req_addr  = 32'h100;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checkOutput("pre-drop read_dp", {31'h0, bus.read_dp}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("drop read_dp", {31'h0, bus.read_dp}, 32'h0);
        checkOutput("drop resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        checkOutput("drop req_ready", {31'h0, bus.req_ready}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("drop resp_valid after", {31'h0, bus.resp_valid}, 32'h0);
        last_data = 32'h0;
        applyStimulus(recov);

        @(negedge clk);
        checkOutput("scoreboard empty", sb_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
